// File: rtl/tinyrv1_pkg.sv
// tinyrv1_pkg: encodings and enums shared by the multi-cycle control unit
package tinyrv1_pkg;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_MUL    = 7'b0000001;
    localparam logic [1:0] IMM_I = 2'd0, IMM_S = 2'd1, IMM_J = 2'd2, IMM_B = 2'd3;
    localparam logic [1:0] PC_PLUS4 = 2'd0, PC_JAL = 2'd1, PC_JR = 2'd2, PC_BR = 2'd3;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_MUL = 2'd2, WB_PC4 = 2'd3;
    typedef enum logic [3:0] {
        S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_MUL, S_MULWAIT, S_HALT
    } state_t;
    typedef enum logic [3:0] {
        C_ADD, C_MUL, C_ADDI, C_LW, C_SW, C_JAL, C_JR, C_BNE, C_ILL
    } iclass_t;
endpackage

// File: rtl/proc_ctrl_decode.sv
// proc_ctrl_decode: classifies the instruction register into class, immediate format and legality
module proc_ctrl_decode
    import tinyrv1_pkg::*;
(
    input  logic [31:0] i_inst,
    output iclass_t     o_cls,
    output logic [1:0]  o_imm_type,
    output logic        o_illegal
);
    logic [6:0] w_op;
    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic       w_unused;
    assign w_unused = ^i_inst[19:15];
    always_comb begin
        w_op = i_inst[6:0];
        w_f3 = i_inst[14:12];
        w_f7 = i_inst[31:25];
        o_cls = (w_op == OP_OP && w_f3 == F3_ADD && w_f7 == F7_ADD) ? C_ADD :
                (w_op == OP_OP && w_f3 == F3_ADD && w_f7 == F7_MUL) ? C_MUL :
                (w_op == OP_IMM && w_f3 == F3_ADD)                  ? C_ADDI :
                (w_op == OP_LOAD && w_f3 == F3_LW)                  ? C_LW :
                (w_op == OP_STORE && w_f3 == F3_LW)                 ? C_SW :
                (w_op == OP_JAL)                                    ? C_JAL :
                (w_op == OP_JALR && w_f3 == F3_ADD && i_inst[11:7] == 5'd0 && i_inst[31:20] == 12'd0) ? C_JR :
                (w_op == OP_BRANCH && w_f3 == F3_BNE)               ? C_BNE : C_ILL;
        o_imm_type = (o_cls == C_SW)  ? IMM_S :
                     (o_cls == C_JAL) ? IMM_J :
                     (o_cls == C_BNE) ? IMM_B : IMM_I;
        o_illegal = o_cls == C_ILL;
    end
endmodule

// File: rtl/proc_multicycle_ctrl.sv
// proc_multicycle_ctrl: sequences fetch/decode/execute/memory/writeback for the multi-cycle TinyRV1 datapath
module proc_multicycle_ctrl
    import tinyrv1_pkg::*;
#(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        eq,
    output logic        mem_req_val,
    input  logic        mem_req_rdy,
    output logic        mem_req_type,
    output logic        mem_addr_sel,
    input  logic        mem_resp_val,
    output logic        mul_req_val,
    input  logic        mul_req_rdy,
    input  logic        mul_resp_val,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic [1:0]  imm_type,
    output logic        op2_sel,
    output logic        rf_wen,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        halted
);
    state_t     r_state;
    logic       r_illegal;
    iclass_t    w_cls;
    logic [1:0] w_imm;
    logic       w_ill;
    logic       w_ex;
    logic       w_mem_done;
    logic       w_mul_done;

    proc_ctrl_decode u_decode (
        .i_inst     (inst),
        .o_cls      (w_cls),
        .o_imm_type (w_imm),
        .o_illegal  (w_ill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RESET_HALT ? S_HALT : S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:   if (mem_req_rdy) r_state <= S_FWAIT;
                S_FWAIT:   if (mem_resp_val) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_ill) r_illegal <= 1'b1;
                    r_state <= w_ill ? S_HALT :
                               (w_cls == C_MUL) ? S_MUL :
                               (w_cls == C_LW || w_cls == C_SW) ? S_MEM : S_EXEC;
                end
                S_EXEC:    r_state <= S_FETCH;
                S_MEM:     if (mem_req_rdy) r_state <= S_MWAIT;
                S_MWAIT:   if (mem_resp_val) r_state <= S_FETCH;
                S_MUL:     if (mul_req_rdy) r_state <= S_MULWAIT;
                S_MULWAIT: if (mul_resp_val) r_state <= S_FETCH;
                default:   r_state <= S_HALT;
            endcase
        end
    end

    // Outputs are Mealy: handshake responses must act in the cycle they arrive
    always_comb begin
        w_ex         = r_state == S_EXEC;
        w_mem_done   = r_state == S_MWAIT && mem_resp_val;
        w_mul_done   = r_state == S_MULWAIT && mul_resp_val;
        mem_req_val  = r_state == S_FETCH || r_state == S_MEM;
        mem_req_type = r_state == S_MEM && w_cls == C_SW;
        mem_addr_sel = r_state == S_MEM;
        mul_req_val  = r_state == S_MUL;
        ir_en        = r_state == S_FWAIT && mem_resp_val;
        pc_en        = w_ex || w_mem_done || w_mul_done;
        pc_sel       = !w_ex ? PC_PLUS4 :
                       (w_cls == C_JAL) ? PC_JAL :
                       (w_cls == C_JR) ? PC_JR :
                       (w_cls == C_BNE && !eq) ? PC_BR : PC_PLUS4;
        imm_type     = (r_state == S_DECODE || w_ex || r_state == S_MEM) ? w_imm : IMM_I;
        op2_sel      = (w_ex && w_cls == C_ADDI) || r_state == S_MEM;
        rf_wen       = (w_ex && (w_cls == C_ADD || w_cls == C_ADDI || w_cls == C_JAL)) ||
                       (w_mem_done && w_cls == C_LW) || w_mul_done;
        wb_sel       = (w_ex && w_cls == C_JAL) ? WB_PC4 :
                       w_mul_done ? WB_MUL :
                       (w_mem_done && w_cls == C_LW) ? WB_MEM : WB_ALU;
        illegal      = r_illegal;
        halted       = r_state == S_HALT;
    end
endmodule
